// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-block SRAM front-end controller.
// One block is 16 byte-wide words, moved as a single 128-bit beat.
package sram_ctrl_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int WORD_W      = 8;
    localparam int DATA_W      = BLOCK_WORDS * WORD_W;
    localparam int ADDR_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_block_ctrl.sv
// Request/response front-end for the on-chip block SRAM: holds address, data and
// one enable for a fixed access window, then returns a single response per request.
module sram_block_ctrl #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 128,
    parameter int ACCESS_CYCLES = 2,
    parameter int ALIGN_BITS    = 4
) (
    input  logic              clk,
    input  logic              n_rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic              rsp_err,

    output logic              sram_read_enable,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    import sram_ctrl_pkg::*;

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              aligned;

    assign aligned = (req_addr[ALIGN_BITS-1:0] == '0);

    // NOTE: every _d starts as a copy of its _q so no path through the case leaves a
    // signal unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_ready_d = 1'b0;
                    if (aligned) begin
                        cnt_d   = CNT_LOAD;
                        rd_en_d = ~req_write;
                        wr_en_d = req_write;
                        state_d = ACCESS;
                    end else begin
                        // Misaligned: answer straight away without touching the SRAM.
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    rd_en_d     = 1'b0;
                    wr_en_d     = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = req_q.write ? '0 : sram_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                rd_en_d     = 1'b0;
                wr_en_d     = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; the combinational block above uses blocking assignments.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
        end
    end

    // Address and data come straight from the request register, so they are stable
    // across the access window and hold their last value afterwards.
    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_write         = req_q.write;
    assign rsp_err           = rsp_err_q;
    assign sram_read_enable  = rd_en_q;
    assign sram_write_enable = wr_en_q;
    assign sram_addr         = req_q.addr;
    assign sram_wdata        = req_q.wdata;

endmodule

// File: tb/tb_sram_block_ctrl.sv
// Bench for sram_block_ctrl: three instances (access window 1, 2, 3 cycles), each with a
// behavioural block SRAM, driven with directed and random requests against a reference model.
module tb_sram_block_ctrl;

    localparam int  N_INST = 3;
    localparam time PERIOD = 10;

    logic         clk;
    logic         n_rst;
    logic         req_valid [N_INST];
    logic         req_ready [N_INST];
    logic         req_write [N_INST];
    logic [15:0]  req_addr  [N_INST];
    logic [127:0] req_wdata [N_INST];
    logic         rsp_valid [N_INST];
    logic         rsp_ready [N_INST];
    logic [127:0] rsp_rdata [N_INST];
    logic         rsp_write [N_INST];
    logic         rsp_err   [N_INST];
    logic         sram_rd   [N_INST];
    logic         sram_we   [N_INST];
    logic [15:0]  sram_addr [N_INST];
    logic [127:0] sram_wdata[N_INST];
    logic [127:0] sram_rdata[N_INST];

    // Behavioural SRAM storage, one 4096-block array per instance.
    logic [127:0] sram_mem [N_INST][4096];

    // Reference model: block contents by (instance, block address).
    logic [127:0] ref_mem [int];

    int  n_tests;
    int  n_fail;
    int  excl_viol;
    int  gap_exp     [N_INST];
    time last_accept [N_INST];

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        sram_block_ctrl #(
            .ADDR_W       (16),
            .DATA_W       (128),
            .ACCESS_CYCLES(g + 1),
            .ALIGN_BITS   (4)
        ) u_dut (
            .clk              (clk),
            .n_rst            (n_rst),
            .req_valid        (req_valid[g]),
            .req_ready        (req_ready[g]),
            .req_write        (req_write[g]),
            .req_addr         (req_addr[g]),
            .req_wdata        (req_wdata[g]),
            .rsp_valid        (rsp_valid[g]),
            .rsp_ready        (rsp_ready[g]),
            .rsp_rdata        (rsp_rdata[g]),
            .rsp_write        (rsp_write[g]),
            .rsp_err          (rsp_err[g]),
            .sram_read_enable (sram_rd[g]),
            .sram_write_enable(sram_we[g]),
            .sram_addr        (sram_addr[g]),
            .sram_wdata       (sram_wdata[g]),
            .sram_rdata       (sram_rdata[g])
        );
        assign sram_rdata[g] = sram_rd[g] ? sram_mem[g][sram_addr[g][15:4]] : '0;
    end

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    always @(posedge clk) begin
        for (int g = 0; g < N_INST; g++)
            if (sram_we[g]) sram_mem[g][sram_addr[g][15:4]] <= sram_wdata[g];
    end

    always @(negedge clk) begin
        for (int g = 0; g < N_INST; g++)
            if (sram_rd[g] && sram_we[g]) excl_viol++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request/response transaction on instance i, with the response held
    // off for `hold` cycles. Expectations come from the access-window rules and ref_mem.
    task automatic do_req(input int i, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, input int hold);
        int           ac, exp_lat, lat, n, rd_n, wr_n, bad_busy, bad_bus, bad_hold, key;
        logic         aligned;
        logic [127:0] exp_data, held;
        ac       = i + 1;
        aligned  = (addr[3:0] == 4'h0);
        exp_lat  = aligned ? ac : 0;
        key      = i * 65536 + int'(addr);
        exp_data = '0;
        if (aligned && !wr && ref_mem.exists(key)) exp_data = ref_mem[key];

        @(negedge clk);
        check("req_ready_idle", req_ready[i], 1'b1);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        @(posedge clk);
        if (gap_exp[i] >= 0) check("accept_gap", ($time - last_accept[i]) / PERIOD, gap_exp[i]);
        last_accept[i] = $time;
        #1;
        req_valid[i] = 1'b0;
        req_addr[i]  = 16'($urandom);
        req_wdata[i] = {4{$urandom}};

        lat = -1; n = 0; rd_n = 0; wr_n = 0; bad_busy = 0; bad_bus = 0;
        while (lat < 0 && n < 16) begin
            @(negedge clk);
            rd_n += int'(sram_rd[i]);
            wr_n += int'(sram_we[i]);
            if ((sram_rd[i] || sram_we[i]) &&
                (sram_addr[i] !== addr || (wr && sram_wdata[i] !== wd))) bad_bus++;
            if (req_ready[i]) bad_busy++;
            if (rsp_valid[i]) lat = n;
            n++;
        end
        check("rsp_latency", lat, exp_lat);
        check("rd_en_cycles", rd_n, (aligned && !wr) ? ac : 0);
        check("wr_en_cycles", wr_n, (aligned && wr) ? ac : 0);
        check("sram_bus_stable", bad_bus, 0);

        held = rsp_rdata[i];
        bad_hold = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_valid[i] || rsp_rdata[i] !== held || rsp_err[i] !== !aligned ||
                sram_rd[i] || sram_we[i] || req_ready[i]) bad_hold++;
        end
        check("rsp_rdata", rsp_rdata[i], exp_data);
        check("rsp_write", rsp_write[i], wr);
        check("rsp_err", rsp_err[i], !aligned);
        check("busy_no_ready", bad_busy + bad_hold, 0);

        rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[i] = 1'b0;
        if (aligned && wr) ref_mem[key] = wd;
        gap_exp[i] = exp_lat + hold + 2;
    endtask

    initial begin
        logic [127:0] d;
        logic [15:0]  a;
        logic         w;
        int           key, bad;

        n_tests = 0; n_fail = 0; excl_viol = 0;
        for (int i = 0; i < N_INST; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   rsp_ready[i] = 1'b0;
            gap_exp[i] = -1;     last_accept[i] = 0;
        end
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        for (int i = 0; i < N_INST; i++) begin
            check("reset_ctrl", {req_ready[i], rsp_valid[i], rsp_write[i], rsp_err[i],
                                 sram_rd[i], sram_we[i]}, 6'b100000);
            check("reset_data", {sram_addr[i], rsp_rdata[i] | sram_wdata[i]}, '0);
        end
        @(negedge clk);
        n_rst = 1'b1;

        // Directed traffic on the two-cycle instance.
        do_req(1, 1'b1, 16'h0010, 128'h00112233445566778899AABBCCDDEEFF, 0);
        do_req(1, 1'b0, 16'h0010, '0, 0);
        do_req(1, 1'b0, 16'h0013, '0, 0);
        do_req(1, 1'b1, 16'h0000, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0);
        do_req(1, 1'b0, 16'h0000, '0, 5);
        do_req(1, 1'b0, 16'h0010, '0, 0);
        do_req(1, 1'b1, 16'h0000, {4{32'hC0DE_0000}}, 0);
        do_req(1, 1'b1, 16'h0010, {4{32'hC0DE_0010}}, 0);
        do_req(1, 1'b1, 16'h0020, {4{32'hC0DE_0020}}, 0);
        do_req(1, 1'b1, 16'hFFF0, {4{32'hC0DE_FFF0}}, 0);
        do_req(1, 1'b0, 16'h0000, '0, 0);
        do_req(1, 1'b0, 16'h0010, '0, 0);
        do_req(1, 1'b0, 16'h0020, '0, 0);
        do_req(1, 1'b0, 16'hFFF0, '0, 0);

        // Reset in the middle of a write: enables drop at once, no response, no SRAM update.
        do_req(1, 1'b1, 16'h0040, {4{32'h0BAD_F00D}}, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1;
        req_addr[1] = 16'h0040; req_wdata[1] = {4{32'hDEAD_BEEF}};
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        #2;
        check("midwrite_we", sram_we[1], 1'b1);
        n_rst = 1'b0;
        #1;
        check("reset_mid_en", {sram_we[1], sram_rd[1]}, 2'b00);
        check("reset_mid_rdy", {req_ready[1], rsp_valid[1]}, 2'b10);
        @(negedge clk);
        n_rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid[1]) bad++;
        end
        check("no_rsp_after_reset", bad, 0);
        for (int i = 0; i < N_INST; i++) gap_exp[i] = -1;
        do_req(1, 1'b0, 16'h0040, '0, 0);

        // Random traffic on every access-window width.
        for (int i = 0; i < N_INST; i++) begin
            gap_exp[i] = -1;
            for (int t = 0; t < 40; t++) begin
                a = ($urandom_range(0, 16) == 16) ? 16'hFFF0 : 16'($urandom_range(0, 15) * 16);
                if ($urandom_range(0, 7) == 0) a = a | 16'($urandom_range(1, 15));
                w = 1'($urandom);
                key = i * 65536 + int'(a);
                if (!w && a[3:0] == 4'h0 && !ref_mem.exists(key)) w = 1'b1;
                d = {$urandom, $urandom, $urandom, $urandom};
                do_req(i, w, a, d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            end
        end

        check("rd_we_exclusive", excl_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
